muldiv_sequencer: RTL and testbench

//  Iterative multi-cycle multiply/divide engine for MULT/MULTU/DIV/DIVU, sitting beside the ALU.

---
 rtl/muldiv_pkg.sv | 51 +++++
 rtl/muldiv_if.sv | 28 ++
 rtl/muldiv_step.sv | 44 ++++
 rtl/muldiv_sequencer.sv | 142 ++++++++++++++
 tb/tb_muldiv_sequencer.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// Shared types for the multiply/divide unit.
// Holds the operation and FSM state encodings, plus the mapping from the
// instruction func code to an operation. The control unit uses the same mapping.
package muldiv_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'd0,
        MD_MULTU = 2'd1,
        MD_DIV   = 2'd2,
        MD_DIVU  = 2'd3
    } muldiv_op_e;

    typedef enum logic [1:0] {
        MD_IDLE,
        MD_RUN,
        MD_FIX,
        MD_DONE
    } muldiv_state_e;

    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

    // Callers qualify with is_muldiv_funct(); an unknown code maps to MULT.
    function automatic muldiv_op_e func_to_op(input logic [5:0] funct);
        muldiv_op_e op;
        case (funct)
            FUNCT_MULT:  op = MD_MULT;
            FUNCT_MULTU: op = MD_MULTU;
            FUNCT_DIV:   op = MD_DIV;
            FUNCT_DIVU:  op = MD_DIVU;
            default:     op = MD_MULT;
        endcase
        return op;
    endfunction

    function automatic logic is_muldiv_funct(input logic [5:0] funct);
        return (funct == FUNCT_MULT) || (funct == FUNCT_MULTU) ||
               (funct == FUNCT_DIV)  || (funct == FUNCT_DIVU);
    endfunction

    function automatic logic op_is_div(input muldiv_op_e op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic op_is_signed(input muldiv_op_e op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Core <-> multiply/divide unit bus.
//   master (core/control side): drives start, op, a, b; receives busy, done,
//                               stall, div_by_zero, hi, lo
//   slave  (muldiv_sequencer) : the reverse
interface muldiv_if import muldiv_pkg::*; #(
    parameter int unsigned WIDTH = 32
) ();
    logic             start;
    muldiv_op_e       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             stall;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b,
        input  busy, done, stall, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, stall, div_by_zero, hi, lo
    );
endinterface

// File: rtl/muldiv_step.sv
// One iteration of the multiply/divide engine (purely combinational).
// Ports:
//   is_div   - 1: restoring divide step, 0: shift-add multiply step
//   acc      - 2W+1 accumulator
//              multiply: {upper partial product (W+1), multiplier bits (W)}
//              divide:   {partial remainder (W+1), dividend/quotient bits (W)}
//   operand  - multiplicand (multiply) or divisor (divide)
//   acc_next - accumulator after this iteration
// WIDTH must be at least 2.
module muldiv_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic               is_div,
    input  logic [2*WIDTH:0]   acc,
    input  logic [WIDTH-1:0]   operand,
    output logic [2*WIDTH:0]   acc_next
);
    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    always_comb begin
        sum      = '0;
        shifted  = '0;
        diff     = '0;
        acc_next = '0;
        if (!is_div) begin
            // Add the multiplicand when the current multiplier LSB is set, then
            // shift the whole accumulator right; the carry lands in the top half.
            sum      = acc[2*WIDTH:WIDTH] + {1'b0, (acc[0] ? operand : '0)};
            acc_next = {1'b0, sum, acc[WIDTH-1:1]};
        end else begin
            // Bring the next dividend bit into the remainder and try to subtract.
            // The remainder stays below the divisor, so the top bit is free for the borrow.
            shifted = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
            diff    = shifted - {1'b0, operand};
            if (shifted >= {1'b0, operand}) begin
                acc_next = {diff, acc[WIDTH-2:0], 1'b1};
            end else begin
                acc_next = {shifted, acc[WIDTH-2:0], 1'b0};
            end
        end
    end
endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU engine beside the ALU.
// It runs one shift-add or restoring-subtract step per cycle on operand
// magnitudes. The FIX state applies the sign correction and writes HI/LO.
// It stalls the core while an operation runs.
// Ports:
//   clk   - system clock, rising edge
//   rst_b - asynchronous active-low reset
//   bus   - muldiv_if slave: start/op/a/b in; busy/done/stall/div_by_zero/hi/lo out
// Timing: RUN lasts WIDTH cycles, then FIX for 1 cycle, then DONE for 1 cycle.
// A divide by zero skips RUN, but still passes through FIX so that its result
// uses the same write-back path. Its done therefore comes 2 cycles after the start edge.
module muldiv_sequencer import muldiv_pkg::*; #(
    parameter int unsigned WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst_b,
    muldiv_if.slave  bus
);
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    muldiv_state_e      state, state_next;
    muldiv_op_e         op_r;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic               neg_res, neg_rem, div0;
    logic [CW-1:0]      count;
    logic [2*WIDTH:0]   acc, acc_step;
    logic [WIDTH-1:0]   hi_r, lo_r;
    logic               dbz_r;

    // Decode of the request presented in IDLE.
    logic               start_div, start_signed, start_div0, a_neg, b_neg;
    logic [WIDTH-1:0]   a_abs, b_abs;

    // Result computed in FIX.
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   hi_fix, lo_fix;

    logic               op_div;
    logic               busy_w;

    assign op_div = op_is_div(op_r);

    always_comb begin
        start_div    = op_is_div(bus.op);
        start_signed = op_is_signed(bus.op);
        a_neg        = start_signed & bus.a[WIDTH-1];
        b_neg        = start_signed & bus.b[WIDTH-1];
        // |INT_MIN| wraps back to 2^(W-1), which is the correct unsigned magnitude.
        a_abs        = a_neg ? -bus.a : bus.a;
        b_abs        = b_neg ? -bus.b : bus.b;
        start_div0   = start_div && (bus.b == '0);
    end

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div   (op_div),
        .acc      (acc),
        .operand  (op_div ? b_mag : a_mag),
        .acc_next (acc_step)
    );

    always_comb begin
        state_next = state;
        case (state)
            MD_IDLE: if (bus.start) state_next = start_div0 ? MD_FIX : MD_RUN;
            MD_RUN:  if (count == '0) state_next = MD_FIX;
            MD_FIX:  state_next = MD_DONE;
            MD_DONE: state_next = MD_IDLE;
            default: state_next = MD_IDLE;
        endcase
    end

    always_comb begin
        prod   = '0;
        hi_fix = '0;
        lo_fix = '0;
        if (div0) begin
            // For a divide by zero, a_mag holds the raw dividend.
            hi_fix = a_mag;
            lo_fix = '1;
        end else if (!op_div) begin
            prod = acc[2*WIDTH-1:0];
            if (neg_res) prod = -prod;
            {hi_fix, lo_fix} = prod;
        end else begin
            // The quotient sign follows sign(a)^sign(b); the remainder takes the dividend's sign.
            lo_fix = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
            hi_fix = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state   <= MD_IDLE;
            op_r    <= MD_MULT;
            a_mag   <= '0;
            b_mag   <= '0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            div0    <= 1'b0;
            count   <= '0;
            acc     <= '0;
            hi_r    <= '0;
            lo_r    <= '0;
            dbz_r   <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                MD_IDLE: begin
                    if (bus.start) begin
                        op_r    <= bus.op;
                        a_mag   <= start_div0 ? bus.a : a_abs;
                        b_mag   <= b_abs;
                        neg_res <= a_neg ^ b_neg;
                        neg_rem <= a_neg;
                        div0    <= start_div0;
                        count   <= CW'(WIDTH - 1);
                        dbz_r   <= 1'b0;
                        acc     <= {{(WIDTH+1){1'b0}}, (start_div ? a_abs : b_abs)};
                    end
                end
                MD_RUN: begin
                    acc <= acc_step;
                    if (count != '0) count <= count - CW'(1);
                end
                MD_FIX: begin
                    hi_r  <= hi_fix;
                    lo_r  <= lo_fix;
                    dbz_r <= div0;
                end
                default: ;
            endcase
        end
    end

    assign busy_w          = (state == MD_RUN) || (state == MD_FIX);
    assign bus.busy        = busy_w;
    assign bus.done        = (state == MD_DONE);
    assign bus.stall       = busy_w | (bus.start & (state == MD_IDLE));
    assign bus.div_by_zero = dbz_r;
    assign bus.hi          = hi_r;
    assign bus.lo          = lo_r;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer at WIDTH=32.
// Directed cases carry their expected results as constants. Random cases take
// their expected results from a plain-arithmetic reference model. A monitor
// pops one expected entry per done pulse. It checks hi/lo/div_by_zero, the
// latency counted from the start edge (done in the 34th cycle, or the 2nd for
// a divide by zero), the number of stalled cycles, and that hi/lo hold their
// value while the unit is busy.
module tb_muldiv_sequencer;
    import muldiv_pkg::*;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          lat;
        int          start_cyc;
    } exp_t;

    logic clk;
    logic rst_b;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   cur_start = 1 << 30;
    int   stall_cnt = 0;
    logic [31:0] last_hi = '0;
    logic [31:0] last_lo = '0;
    exp_t sb[$];
    exp_t mon_e;

    muldiv_if #(.WIDTH(32)) bus ();

    muldiv_sequencer #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input muldiv_op_e op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        logic signed [63:0] sa, sb_, sq, sr;
        logic [63:0] p;
        sa = {{32{a[31]}}, a};
        sb_ = {{32{b[31]}}, b};
        e.dbz = 1'b0;
        e.lat = 34;
        e.start_cyc = 0;
        e.hi = '0;
        e.lo = '0;
        case (op)
            MD_MULT:  begin p = sa * sb_; e.hi = p[63:32]; e.lo = p[31:0]; end
            MD_MULTU: begin p = {32'b0, a} * {32'b0, b}; e.hi = p[63:32]; e.lo = p[31:0]; end
            default: begin
                if (b == 0) begin
                    e.hi = a; e.lo = 32'hFFFF_FFFF; e.dbz = 1'b1; e.lat = 2;
                end else if (op == MD_DIV) begin
                    sq = sa / sb_; sr = sa % sb_;
                    e.lo = sq[31:0]; e.hi = sr[31:0];
                end else begin
                    e.lo = a / b; e.hi = a % b;
                end
            end
        endcase
        return e;
    endfunction

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (!rst_b) begin
            stall_cnt = 0;
            last_hi = '0;
            last_lo = '0;
        end else if (bus.done) begin
            if (sb.size() == 0) begin
                chk("spurious_done", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                chk("hi", bus.hi, mon_e.hi);
                chk("lo", bus.lo, mon_e.lo);
                chk("div_by_zero", bus.div_by_zero, mon_e.dbz);
                chk("latency", cyc - mon_e.start_cyc + 1, mon_e.lat);
                chk("stall_cycles", stall_cnt, mon_e.lat - 1);
                chk("stall_in_done", bus.stall, 0);
                last_hi = mon_e.hi;
                last_lo = mon_e.lo;
            end
            stall_cnt = 0;
        end else begin
            if (bus.stall && cyc >= cur_start) stall_cnt++;
            if (bus.busy) begin
                chk("hold_hi", bus.hi, last_hi);
                chk("hold_lo", bus.lo, last_lo);
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while ((bus.busy || bus.done) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("idle_wait_timeout", n >= 200, 0);
    endtask

    task automatic issue(input logic [5:0] funct, input logic [31:0] a, input logic [31:0] b, input exp_t e);
        wait_idle();
        e.start_cyc = cyc + 1;
        cur_start = cyc + 1;
        sb.push_back(e);
        bus.op = func_to_op(funct);
        bus.a = a;
        bus.b = b;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    task automatic issue_rand_model(input logic [5:0] funct, input logic [31:0] a, input logic [31:0] b);
        issue(funct, a, b, model(func_to_op(funct), a, b));
    endtask

    localparam int ND = 11;
    logic [5:0]  d_f  [ND] = '{FUNCT_MULT, FUNCT_MULTU, FUNCT_DIVU, FUNCT_DIV, FUNCT_DIV, FUNCT_DIV,
                               FUNCT_DIVU, FUNCT_DIV, FUNCT_MULT, FUNCT_DIV, FUNCT_MULTU};
    logic [31:0] d_a  [ND] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd100, 32'hFFFF_FFF9, 32'h8000_0000, 32'd5,
                               32'hDEAD_BEEF, 32'd7, 32'h8000_0000, 32'hFFFF_FFF9, 32'h0001_0000};
    logic [31:0] d_b  [ND] = '{32'd7, 32'hFFFF_FFFF, 32'd7, 32'd2, 32'hFFFF_FFFF, 32'd0,
                               32'd0, 32'hFFFF_FFFE, 32'h8000_0000, 32'd0, 32'h0001_0000};
    logic [31:0] d_hi [ND] = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd2, 32'hFFFF_FFFF, 32'd0, 32'd5,
                               32'hDEAD_BEEF, 32'd1, 32'h4000_0000, 32'hFFFF_FFF9, 32'd1};
    logic [31:0] d_lo [ND] = '{32'hFFFF_FFEB, 32'h0000_0001, 32'd14, 32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF,
                               32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'd0, 32'hFFFF_FFFF, 32'd0};
    logic        d_z  [ND] = '{0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 0};
    logic [5:0]  codes[4]  = '{FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU};

    initial begin
        exp_t e;
        logic [31:0] ra, rb;
        int n;
        rst_b = 1'b0;
        bus.start = 1'b0;
        bus.op = MD_MULT;
        bus.a = '0;
        bus.b = '0;
        #1;
        chk("reset_busy", bus.busy, 0);
        chk("reset_done", bus.done, 0);
        chk("reset_stall", bus.stall, 0);
        chk("reset_dbz", bus.div_by_zero, 0);
        chk("reset_hi", bus.hi, 0);
        chk("reset_lo", bus.lo, 0);
        repeat (3) @(negedge clk);
        rst_b = 1'b1;

        // Directed cases with constant expectations.
        for (int i = 0; i < ND; i++) begin
            e.hi = d_hi[i];
            e.lo = d_lo[i];
            e.dbz = d_z[i];
            e.lat = d_z[i] ? 2 : 34;
            e.start_cyc = 0;
            issue(d_f[i], d_a[i], d_b[i], e);
        end

        // A start while busy must be ignored; the DIVU result must be unaffected.
        e.hi = 32'd2; e.lo = 32'd14; e.dbz = 1'b0; e.lat = 34; e.start_cyc = 0;
        issue(FUNCT_DIVU, 32'd100, 32'd7, e);
        repeat (5) @(negedge clk);
        bus.op = MD_MULT; bus.a = $urandom; bus.b = $urandom; bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;

        // A start raised in the DONE cycle must be ignored as well.
        n = 0;
        while (!bus.done && n < 200) begin @(negedge clk); n++; end
        chk("done_wait_timeout", n >= 200, 0);
        bus.op = MD_DIVU; bus.a = 32'd9; bus.b = 32'd3; bus.start = 1'b1;
        #1 chk("stall_start_in_done", bus.stall, 0);
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (40) @(negedge clk);
        chk("no_op_after_done_start", bus.busy, 0);
        chk("hi_kept_after_ignored", bus.hi, 32'd2);
        chk("lo_kept_after_ignored", bus.lo, 32'd14);

        // Asynchronous reset in RUN cycle 10 aborts with no done pulse.
        issue_rand_model(FUNCT_MULTU, $urandom, $urandom);
        repeat (9) @(posedge clk);
        #3 rst_b = 1'b0;
        #1;
        sb.delete();
        chk("abort_busy", bus.busy, 0);
        chk("abort_done", bus.done, 0);
        chk("abort_hi", bus.hi, 0);
        chk("abort_lo", bus.lo, 0);
        chk("abort_dbz", bus.div_by_zero, 0);
        repeat (2) @(negedge clk);
        rst_b = 1'b1;
        e.hi = 32'hFFFF_FFFF; e.lo = 32'hFFFF_FFEB; e.dbz = 1'b0; e.lat = 34; e.start_cyc = 0;
        issue(FUNCT_MULT, 32'hFFFF_FFFD, 32'd7, e);

        // Randomised operations, with the corner operands weighted up.
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 7))
                0: ra = 32'h8000_0000;
                1: ra = $urandom_range(0, 20);
                2: ra = 32'hFFFF_FFFF;
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'hFFFF_FFFF;
                2: rb = $urandom_range(1, 20);
                default: rb = $urandom;
            endcase
            issue_rand_model(codes[$urandom_range(0, 3)], ra, rb);
        end

        n = 0;
        while (sb.size() != 0 && n < 200) begin @(negedge clk); n++; end
        chk("drain", sb.size(), 0);
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
